// File: rtl/fuzz_harness_pkg.sv
// rtl/fuzz_harness_pkg.sv - shared types, polynomials and LFSR step for the fuzz harness
package fuzz_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_FLUSH,
    ST_DONE
  } run_state_t;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam int IN_W_DEF = 43;
  localparam int Y_W_DEF  = 246;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/fuzz_lfsr64.sv
// rtl/fuzz_lfsr64.sv - 64-bit right-shift Galois LFSR with synchronous load
module fuzz_lfsr64
  import fuzz_harness_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [63:0] seed,
  output logic [63:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 64'h0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/fuzz_run_ctrl.sv
// rtl/fuzz_run_ctrl.sv - sequences one A/B identity run: LFSR stimulus, flush, compare and MISR
module fuzz_run_ctrl
  import fuzz_harness_pkg::*;
#(
  parameter int          IN_W         = IN_W_DEF,
  parameter int          Y_W          = Y_W_DEF,
  parameter logic [63:0] SEED         = 64'h1,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     num_vectors,
  output logic [IN_W-1:0] stim_o,
  input  logic [Y_W-1:0]  dut_a_y,
  input  logic [Y_W-1:0]  dut_b_y,
  output logic            busy,
  output logic            done,
  output logic [15:0]     mismatch_cnt,
  output logic            first_fail_valid,
  output logic [15:0]     first_fail_idx,
  output logic [31:0]     signature
);

  localparam logic [63:0] SEED_NZ = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam int          PAD_W   = ((Y_W + 31) / 32) * 32;

  run_state_t  state, state_next;
  logic [15:0] remaining, remaining_next;
  logic [15:0] cmp_idx;
  logic        run_start, lfsr_load, lfsr_adv, stim_step;
  logic [63:0] lfsr_state, lfsr_next;
  logic        lfsr_unused;
  logic [PAD_W-1:0] y_pad;
  logic [31:0] fold, sig_next;
  logic        mismatch;

  fuzz_lfsr64 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED_NZ),
    .state   (lfsr_state)
  );

  // stim_o must already show vector k+1 in the cycle after vector k, so it
  // is loaded from the LFSR's next value while the LFSR itself advances.
  assign lfsr_next   = lfsr_step(lfsr_state);
  assign lfsr_unused = ^lfsr_next[63:IN_W];

  assign busy = (state == ST_DRIVE) || (state == ST_FLUSH);
  assign done = (state == ST_DONE);

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    run_start      = 1'b0;
    lfsr_load      = 1'b0;
    lfsr_adv       = 1'b0;
    stim_step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          lfsr_load = 1'b1;
          if (num_vectors != 16'd0) begin
            state_next     = ST_DRIVE;
            remaining_next = num_vectors;
          end else begin
            state_next     = ST_FLUSH;
            remaining_next = 16'(FLUSH_CYCLES);
          end
        end
      end
      ST_DRIVE: begin
        lfsr_adv = 1'b1;
        if (remaining == 16'd1) begin
          state_next     = ST_FLUSH;
          remaining_next = 16'(FLUSH_CYCLES);
        end else begin
          stim_step      = 1'b1;
          remaining_next = remaining - 16'd1;
        end
      end
      ST_FLUSH: begin
        if (remaining == 16'd1) begin
          state_next = ST_DONE;
        end else begin
          remaining_next = remaining - 16'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Zero-padded fold of A's output into one 32-bit word per cycle.
  always_comb begin
    y_pad = PAD_W'(dut_a_y);
    fold  = 32'h0;
    for (int i = 0; i < PAD_W / 32; i++) begin
      fold = fold ^ y_pad[i*32 +: 32];
    end
  end

  assign sig_next = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ fold;
  assign mismatch = (dut_a_y != dut_b_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      remaining        <= 16'd0;
      stim_o           <= '0;
      cmp_idx          <= 16'd0;
      mismatch_cnt     <= 16'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 16'd0;
      signature        <= 32'h0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (run_start) begin
        cmp_idx          <= 16'd0;
        mismatch_cnt     <= 16'd0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= 16'd0;
        signature        <= 32'h0;
        if (num_vectors != 16'd0) begin
          stim_o <= SEED_NZ[IN_W-1:0];
        end
      end else if (stim_step) begin
        stim_o <= lfsr_next[IN_W-1:0];
      end
      if (busy) begin
        signature <= sig_next;
        if (cmp_idx != 16'hFFFF) begin
          cmp_idx <= cmp_idx + 16'd1;
        end
        if (mismatch) begin
          if (mismatch_cnt != 16'hFFFF) begin
            mismatch_cnt <= mismatch_cnt + 16'd1;
          end
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= cmp_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fuzz_run_ctrl.sv
// tb/tb_fuzz_run_ctrl.sv - randomized self-checking bench for fuzz_run_ctrl against a run-level model
module tb_fuzz_run_ctrl;

  localparam int          IN_W  = 43;
  localparam int          Y_W   = 246;
  localparam int          FLUSH = 2;
  localparam logic [63:0] SEED  = 64'h1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     num_vectors = 16'd0;
  logic [IN_W-1:0] stim_o;
  logic [Y_W-1:0]  dut_a_y = '0;
  logic [Y_W-1:0]  dut_b_y = '0;
  logic            busy, done, first_fail_valid;
  logic [15:0]     mismatch_cnt, first_fail_idx;
  logic [31:0]     signature;

  int errors = 0;
  int checks = 0;
  logic [IN_W-1:0] model_stim = '0;

  fuzz_run_ctrl #(
    .IN_W(IN_W), .Y_W(Y_W), .SEED(SEED), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .stim_o(stim_o), .dut_a_y(dut_a_y), .dut_b_y(dut_b_y),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
    .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_step(input logic [63:0] s);
    logic [63:0] taps;
    taps = 64'hD800_0000_0000_0000;
    return (s >> 1) ^ (s[0] ? taps : 64'h0);
  endfunction

  function automatic logic [31:0] ref_fold(input logic [Y_W-1:0] y);
    logic [255:0] p;
    logic [31:0]  f;
    p = 256'(y);
    f = 32'h0;
    for (int i = 0; i < 8; i++) f = f ^ p[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [Y_W-1:0] rand_y();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r[Y_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if (stim_o !== '0 || busy !== 1'b0 || done !== 1'b0 || mismatch_cnt !== 16'd0 ||
        first_fail_valid !== 1'b0 || first_fail_idx !== 16'd0 || signature !== 32'h0) begin
      errors++;
      $display("FAIL %s: stim=%h busy=%b done=%b cnt=%h ffv=%b ffi=%h sig=%h required all zero",
               tag, stim_o, busy, done, mismatch_cnt, first_fail_valid, first_fail_idx, signature);
    end
  endtask

  // mode: 0 B=A, 1 flip bit 0 at flip_idx, 2 B=~A, 3 sparse random flips
  task automatic run(input int n, input int mode, input int flip_idx, input bit start_in_flush,
                     input string tag);
    logic [63:0]    vec;
    logic [Y_W-1:0] ya, yb;
    logic [15:0]    exp_cnt, exp_ffi;
    logic           exp_ffv;
    logic [31:0]    exp_sig;
    int             total, bad_stim, bad_busy, bad_done, first_bad;
    total = n + FLUSH;
    exp_cnt = 0; exp_ffi = 0; exp_ffv = 0; exp_sig = 0;
    bad_stim = 0; bad_busy = 0; bad_done = 0; first_bad = -1;
    vec = (SEED == 64'h0) ? 64'h1 : SEED;
    num_vectors = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    num_vectors = 16'($urandom);
    for (int c = 1; c <= total + 1; c++) begin
      if (c <= n) model_stim = vec[IN_W-1:0];
      if (stim_o !== model_stim) begin
        bad_stim++;
        if (first_bad < 0) begin
          first_bad = c;
          $display("FAIL %s stim at cycle %0d: got %h required %h", tag, c, stim_o, model_stim);
        end
      end
      if (busy !== (c <= total)) bad_busy++;
      if (done !== (c == total + 1)) bad_done++;
      if (c <= total) begin
        ya = rand_y();
        case (mode)
          1:       yb = (c - 1 == flip_idx) ? (ya ^ Y_W'(1)) : ya;
          2:       yb = ~ya;
          3:       yb = ($urandom_range(0, 3) == 0) ? (ya ^ (Y_W'(1) << $urandom_range(0, Y_W - 1))) : ya;
          default: yb = ya;
        endcase
        dut_a_y = ya;
        dut_b_y = yb;
        if (ya != yb) begin
          if (exp_cnt != 16'hFFFF) exp_cnt++;
          if (!exp_ffv) begin
            exp_ffv = 1'b1;
            exp_ffi = (c - 1 > 65535) ? 16'hFFFF : 16'(c - 1);
          end
        end
        exp_sig = {exp_sig[30:0], 1'b0} ^ (exp_sig[31] ? 32'h04C1_1DB7 : 32'h0) ^ ref_fold(ya);
      end else begin
        dut_a_y = rand_y();
        dut_b_y = ~dut_a_y;
      end
      start = (start_in_flush && c == n + 1);
      if (start) num_vectors = 16'd7;
      if (c <= n) vec = ref_step(vec);
      tick();
    end
    start = 1'b0;
    checks++;
    if (bad_stim != 0) begin
      errors++;
      $display("FAIL %s stim_trace: bad_cycles=%0d required 0", tag, bad_stim);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s busy_trace: bad_cycles=%0d required 0", tag, bad_busy);
    end
    checks++;
    if (bad_done != 0) begin
      errors++;
      $display("FAIL %s done_trace: bad_cycles=%0d required 0", tag, bad_done);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b required 0 0", tag, busy, done);
    end
    checks++;
    if (mismatch_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s mismatch_cnt: got %h required %h", tag, mismatch_cnt, exp_cnt);
    end
    checks++;
    if (first_fail_valid !== exp_ffv || first_fail_idx !== exp_ffi) begin
      errors++;
      $display("FAIL %s first_fail: got valid=%b idx=%h required valid=%b idx=%h",
               tag, first_fail_valid, first_fail_idx, exp_ffv, exp_ffi);
    end
    checks++;
    if (signature !== exp_sig) begin
      errors++;
      $display("FAIL %s signature: got %h required %h", tag, signature, exp_sig);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset_values");
    rst = 1'b0;
    model_stim = '0;
    tick();
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_drive_flush();
    run(4, 0, 0, 1'b0, "drive_flush");
  endtask

  task automatic test_single_mismatch();
    run(4, 1, 2, 1'b0, "single_mismatch");
  endtask

  task automatic test_abort();
    num_vectors = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 3; c++) begin
      dut_a_y = rand_y();
      dut_b_y = ~dut_a_y;
      tick();
    end
    checks++;
    if (busy !== 1'b1 || mismatch_cnt !== 16'd2) begin
      errors++;
      $display("FAIL abort_pre: busy=%b cnt=%h required 1 0002", busy, mismatch_cnt);
    end
    rst = 1'b1;
    tick();
    check_idle_zero("abort_values");
    rst = 1'b0;
    model_stim = '0;
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 15; c++) begin
        if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        tick();
      end
      checks++;
      if (seen_done != 0) begin
        errors++;
        $display("FAIL abort_no_done: active_cycles=%0d required 0", seen_done);
      end
    end
  endtask

  task automatic test_zero_vectors();
    run(0, 3, 0, 1'b0, "zero_vectors");
  endtask

  task automatic test_ignore_start();
    run(5, 3, 0, 1'b1, "ignore_start");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 5; r++) begin
      run($urandom_range(1, 40), 3, 0, 1'(r & 1), "random_run");
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_back_to_back();
    run(3, 1, 0, 1'b0, "back_to_back_a");
    run(6, 1, 7, 1'b0, "back_to_back_b");
  endtask

  task automatic test_saturation();
    run(65535, 2, 0, 1'b0, "saturation");
  endtask

  initial begin
    test_reset();
    test_drive_flush();
    test_single_mismatch();
    test_abort();
    test_zero_vectors();
    test_ignore_start();
    test_random_runs();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fuzz_run_ctrl.md
# fuzz_run_ctrl

Run controller for the simulation-identity fuzz harness. It sequences one test run across two instances of a generated `top` datapath: one built from the reference netlist (A) and one from the transformed netlist (B). On `start` it drives both instances with the same LFSR-generated input vector every cycle, then holds the stimulus for a flush window. Each cycle it compares the two 246-bit `y` buses, counts mismatches, records the first failing cycle and accumulates a signature of A's output.

## Interface
Parameters:
- `IN_W`, 43, stimulus width; maps to `{wire3[6:0], wire2[16:0], wire1[6:0], wire0[11:0]}`.
- `Y_W`, 246, DUT `y` width.
- `SEED`, 64'h1, LFSR load value; 0 is replaced by 1.
- `FLUSH_CYCLES`, 2, number of compare-only cycles after the last vector; 1..255.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: launches a run; sampled only in IDLE.
- `num_vectors`, in, 16: vector count, latched on `start`.
- `stim_o`, out, IN_W: registered stimulus to both DUTs.
- `dut_a_y`, in, Y_W: output of instance A.
- `dut_b_y`, in, Y_W: output of instance B.
- `busy`, out, 1: high in DRIVE and FLUSH.
- `done`, out, 1: one-cycle pulse in DONE.
- `mismatch_cnt`, out, 16: saturating count of mismatching compare cycles.
- `first_fail_valid`, out, 1: set on the first mismatch of the run.
- `first_fail_idx`, out, 16: compare index of the first mismatch.
- `signature`, out, 32: MISR over `dut_a_y`.

## Operation
- FSM states: IDLE, DRIVE, FLUSH, DONE.
- IDLE with `start`=1:
  - latch `num_vectors`;
  - clear `mismatch_cnt`, `first_fail_*`, `signature` and the compare index;
  - load the LFSR with SEED.
  - Go to DRIVE if `num_vectors`≠0, otherwise go to FLUSH.
- DRIVE:
  - `stim_o` ← LFSR[42:0]; the LFSR then advances.
  - Runs exactly `num_vectors` cycles, then goes to FLUSH.
- FLUSH:
  - `stim_o` holds its last value.
  - Runs FLUSH_CYCLES cycles, then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. Results hold until the next `start`.
- LFSR: 64-bit right-shift Galois, taps 64'hD800_0000_0000_0000. Step rule: `s ← (s>>1) ^ (s[0] ? TAPS : 0)`.
- Compare, on every DRIVE and FLUSH cycle:
  - idx = 0,1,2,…;
  - mismatch = (`dut_a_y` ≠ `dut_b_y`).
  - On mismatch, `mismatch_cnt` increments, saturating at 16'hFFFF.
  - On the first mismatch of the run, `first_fail_valid`←1 and `first_fail_idx`←idx.
  - idx saturates at 16'hFFFF.
- Signature, on the same cycles:
  - fold = XOR of the eight 32-bit slices of `{10'b0, dut_a_y}`;
  - sig ← `{sig[30:0],1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ fold`.
- `start` outside IDLE is ignored.

## Timing
- Reset:
  - state=IDLE;
  - `stim_o`=0, `busy`=0, `done`=0, `mismatch_cnt`=0, `first_fail_valid`=0, `first_fail_idx`=0, `signature`=0.
- `rst` mid-run aborts on the next edge with the same values; no `done` pulse is issued.
- With `start` sampled at edge t:
  - `busy`=1 from cycle t+1;
  - the first vector appears on `stim_o` in cycle t+1 and equals SEED[42:0];
  - `done`=1 in cycle t+1+N+FLUSH_CYCLES, where N = `num_vectors`.
- DUT inputs are sampled combinationally on the edge that ends each DRIVE/FLUSH cycle. DUT register latency is covered by the flush window, not by the compare index.
- The IN_W-bit registered `stim_o` is driven straight into the DUTs, with no extra pipeline stage.
- Total compares per run = N + FLUSH_CYCLES.

## Structure
- Shared package `fuzz_harness_pkg`:
  - state enum;
  - `LFSR_TAPS` (64'hD800_0000_0000_0000);
  - `MISR_POLY` (32'h04C1_1DB7);
  - `IN_W` and `Y_W` defaults.
- One natural sub-module: `fuzz_lfsr64`, with inputs load, advance, seed and output state. Fold, compare and MISR logic stay inline.

## Test plan
- Reset: hold `rst` 3 cycles → every output 0, state IDLE.
- Drive and flush sequence: SEED=1, `num_vectors`=4, FLUSH_CYCLES=2, B tied to A.
  - `stim_o`=43'h1 at t+1 and 43'h0 at t+2.
  - `busy` high t+1..t+6.
  - `done` at t+7.
  - `mismatch_cnt`=0, `first_fail_valid`=0.
- Single mismatch: same run, flip `dut_b_y[0]` only at compare idx 2 → `mismatch_cnt`=1, `first_fail_idx`=2, `first_fail_valid`=1.
- Zero vectors: `num_vectors`=0 → `stim_o` stays 0, `busy` high t+1..t+2, `done` at t+3, 2 compares.
- Abort and ignore:
  - `rst` at DRIVE cycle 3 → next cycle IDLE with all outputs 0.
  - `start` pulsed during FLUSH → run length unchanged.
- Saturation: B=~A for the whole run, `num_vectors`=16'hFFFF → `mismatch_cnt`=16'hFFFF, `first_fail_idx`=0.
